// File: rtl/adder_step_sequencer.sv
// adder_step_sequencer: WIDTH-bit add by stepping a shared 2-bit adder slice; `define ADDER_SEQ_SIGNED_OVF_EN adds signed overflow output ovf
module adder_step_sequencer #(
   parameter int WIDTH   = 4,
   parameter int ADD_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
`ifdef ADDER_SEQ_SIGNED_OVF_EN
   output logic             ovf,
`endif
   output logic             add_fire,
   output logic             add_cin,
   output logic             add_a1,
   output logic             add_a2,
   output logic             add_b1,
   output logic             add_b2,
   input  logic             add_sum1,
   input  logic             add_sum2,
   input  logic             add_cout
);
   localparam int SW = (WIDTH > 2) ? $clog2(WIDTH / 2) : 1;
   localparam logic [SW-1:0] LAST = SW'(WIDTH / 2 - 1);
   localparam logic [1:0] LAT_MAX = 2'(ADD_LAT - 1);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   state_t state;
   logic [WIDTH-1:0] a_r, b_r, pair;
   logic [SW-1:0] step, nstep;
   logic [1:0] lat, a_nx, b_nx;
   logic accept;
   if (WIDTH < 2 || WIDTH % 2 != 0) begin : g_bad_width
      $error("adder_step_sequencer: WIDTH must be even and at least 2");
   end
   if (ADD_LAT < 1 || ADD_LAT > 4) begin : g_bad_lat
      $error("adder_step_sequencer: ADD_LAT must be in 1..4");
   end
   // next operand pair and the captured slice result positioned at the current step
   always_comb begin
      accept = req && (state == IDLE || state == DONE);
      nstep  = step + 1'b1;
      a_nx   = 2'(a_r >> {nstep, 1'b0});
      b_nx   = 2'(b_r >> {nstep, 1'b0});
      pair   = WIDTH'({add_sum2, add_sum1}) << {step, 1'b0};
   end
   // step sequencer; add_cin doubles as the inter-step carry register
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         a_r      <= '0;
         b_r      <= '0;
         step     <= '0;
         lat      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
         add_fire <= 1'b0;
         add_cin  <= 1'b0;
         add_a1   <= 1'b0;
         add_a2   <= 1'b0;
         add_b1   <= 1'b0;
         add_b2   <= 1'b0;
`ifdef ADDER_SEQ_SIGNED_OVF_EN
         ovf      <= 1'b0;
`endif
      end else begin
         done     <= 1'b0;
         add_fire <= 1'b0;
         if (accept) begin
            state    <= ISSUE;
            a_r      <= a;
            b_r      <= b;
            step     <= '0;
            lat      <= '0;
            busy     <= 1'b1;
            sum      <= '0;
            cout     <= 1'b0;
            add_fire <= 1'b1;
            add_cin  <= cin;
            add_a1   <= a[0];
            add_a2   <= a[1];
            add_b1   <= b[0];
            add_b2   <= b[1];
`ifdef ADDER_SEQ_SIGNED_OVF_EN
            ovf      <= 1'b0;
`endif
         end else begin
            case (state)
               ISSUE: begin
                  state <= WAIT;
                  lat   <= '0;
               end
               WAIT: begin
                  if (lat != LAT_MAX) begin
                     lat <= lat + 1'b1;
                  end else begin
                     sum     <= sum | pair;
                     add_cin <= add_cout;
                     if (step == LAST) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        cout    <= add_cout;
                        add_cin <= 1'b0;
                        add_a1  <= 1'b0;
                        add_a2  <= 1'b0;
                        add_b1  <= 1'b0;
                        add_b2  <= 1'b0;
`ifdef ADDER_SEQ_SIGNED_OVF_EN
                        ovf     <= a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ add_sum2 ^ add_cout;
`endif
                     end else begin
                        state    <= ISSUE;
                        step     <= nstep;
                        add_fire <= 1'b1;
                        add_a1   <= a_nx[0];
                        add_a2   <= a_nx[1];
                        add_b1   <= b_nx[0];
                        add_b2   <= b_nx[1];
                     end
                  end
               end
               DONE: state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_adder_step_sequencer.sv
// tb_adder_step_sequencer: scoreboard bench for 4-bit/lat-1 and 8-bit/lat-3 sequencers with latency-accurate adder models
module tb_adder_step_sequencer;
   localparam int L4 = 1;
   localparam int L8 = 3;
   typedef struct {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
      int         cyc;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int cyc = 0;
   int tests = 0;
   int fails = 0;
   exp_t q4[$];
   exp_t q8[$];
   logic req4 = 1'b0, cin4 = 1'b0, busy4, done4, cout4, fire4, acin4, aa1_4, aa2_4, bb1_4, bb2_4, s4l, s4h, s4c;
   logic [3:0] a4 = '0, b4 = '0, sum4;
   logic req8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8, fire8, acin8, aa1_8, aa2_8, bb1_8, bb2_8, s8l, s8h, s8c;
   logic [7:0] a8 = '0, b8 = '0, sum8;
`ifdef ADDER_SEQ_SIGNED_OVF_EN
   logic ovf4, ovf8;
`endif
   logic [2:0] m4_res = '0, m8_res = '0;
   logic [4:0] m4_ops = '0, m8_ops = '0;
   int m4_cnt = 0, m8_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   adder_step_sequencer #(.WIDTH(4), .ADD_LAT(L4)) dut4 (
      .clk(clk), .rst(rst), .req(req4), .a(a4), .b(b4), .cin(cin4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
`ifdef ADDER_SEQ_SIGNED_OVF_EN
      .ovf(ovf4),
`endif
      .add_fire(fire4), .add_cin(acin4), .add_a1(aa1_4), .add_a2(aa2_4),
      .add_b1(bb1_4), .add_b2(bb2_4), .add_sum1(s4l), .add_sum2(s4h), .add_cout(s4c)
   );

   adder_step_sequencer #(.WIDTH(8), .ADD_LAT(L8)) dut8 (
      .clk(clk), .rst(rst), .req(req8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
`ifdef ADDER_SEQ_SIGNED_OVF_EN
      .ovf(ovf8),
`endif
      .add_fire(fire8), .add_cin(acin8), .add_a1(aa1_8), .add_a2(aa2_8),
      .add_b1(bb1_8), .add_b2(bb2_8), .add_sum1(s8l), .add_sum2(s8h), .add_cout(s8c)
   );

   // 2-bit adder models: result valid only on the ADD_LAT-th cycle after the fire, garbage otherwise
   always @(posedge clk) begin
      if (fire4) begin
         m4_res <= {1'b0, aa2_4, aa1_4} + {1'b0, bb2_4, bb1_4} + {2'b0, acin4};
         m4_ops <= {acin4, aa2_4, aa1_4, bb2_4, bb1_4};
         m4_cnt <= L4;
      end else if (m4_cnt > 0) m4_cnt <= m4_cnt - 1;
      if (fire8) begin
         m8_res <= {1'b0, aa2_8, aa1_8} + {1'b0, bb2_8, bb1_8} + {2'b0, acin8};
         m8_ops <= {acin8, aa2_8, aa1_8, bb2_8, bb1_8};
         m8_cnt <= L8;
      end else if (m8_cnt > 0) m8_cnt <= m8_cnt - 1;
   end
   assign {s4c, s4h, s4l} = (m4_cnt == 1) ? m4_res : ~m4_res;
   assign {s8c, s8h, s8l} = (m8_cnt == 1) ? m8_res : ~m8_res;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // scoreboard monitors: each done pulse is matched against the oldest expected result
   always @(negedge clk) begin : mon
      exp_t e;
      if (done4) begin
         if (q4.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL dut4 unexpected done: got sum %0h, none expected (cycle %0d)", sum4, cyc);
         end else begin
            e = q4.pop_front();
            chk("dut4 sum", {28'b0, sum4}, {24'b0, e.sum});
            chk("dut4 cout", {31'b0, cout4}, {31'b0, e.cout});
            chk("dut4 done cycle", cyc, e.cyc);
`ifdef ADDER_SEQ_SIGNED_OVF_EN
            chk("dut4 ovf", {31'b0, ovf4}, {31'b0, e.ovf});
`endif
         end
      end
      if (done8) begin
         if (q8.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL dut8 unexpected done: got sum %0h, none expected (cycle %0d)", sum8, cyc);
         end else begin
            e = q8.pop_front();
            chk("dut8 sum", {24'b0, sum8}, {24'b0, e.sum});
            chk("dut8 cout", {31'b0, cout8}, {31'b0, e.cout});
            chk("dut8 done cycle", cyc, e.cyc);
`ifdef ADDER_SEQ_SIGNED_OVF_EN
            chk("dut8 ovf", {31'b0, ovf8}, {31'b0, e.ovf});
`endif
         end
      end
      if (busy4 && m4_cnt > 0) chk("dut4 operands stable in WAIT", {27'b0, acin4, aa2_4, aa1_4, bb2_4, bb1_4}, {27'b0, m4_ops});
      if (busy8 && m8_cnt > 0) chk("dut8 operands stable in WAIT", {27'b0, acin8, aa2_8, aa1_8, bb2_8, bb1_8}, {27'b0, m8_ops});
   end

   task automatic issue4(input logic [3:0] x, input logic [3:0] y, input logic c, input logic [3:0] es, input logic ec, input logic eo, input bit push);
      req4 = 1'b1;
      a4 = x;
      b4 = y;
      cin4 = c;
      if (push) q4.push_back('{{4'b0, es}, ec, eo, cyc + 1 + 2 * (L4 + 1)});
      @(negedge clk);
      req4 = 1'b0;
   endtask

   task automatic issue8(input logic [7:0] x, input logic [7:0] y, input logic c, input logic [7:0] es, input logic ec, input logic eo);
      req8 = 1'b1;
      a8 = x;
      b8 = y;
      cin8 = c;
      q8.push_back('{es, ec, eo, cyc + 1 + 4 * (L8 + 1)});
      @(negedge clk);
      req8 = 1'b0;
   endtask

   task automatic drain4;
      for (int i = 0; i < 80 && q4.size() != 0; i++) @(negedge clk);
      chk("dut4 pending results delivered", q4.size(), 0);
      q4.delete();
   endtask

   task automatic drain8;
      for (int i = 0; i < 120 && q8.size() != 0; i++) @(negedge clk);
      chk("dut8 pending results delivered", q8.size(), 0);
      q8.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL global timeout at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("dut4 reset outputs", {20'b0, busy4, done4, sum4, cout4, fire4, acin4, aa1_4, aa2_4, bb1_4, bb2_4}, 0);
      chk("dut8 reset outputs", {16'b0, busy8, done8, sum8, cout8, fire8, acin8, aa1_8, aa2_8, bb1_8, bb2_8}, 0);
      rst = 1'b0;
      @(negedge clk);
      // 7+5: fire at T+1, operands of step 0, done at T+5
      issue4(4'b0111, 4'b0101, 1'b0, 4'b1100, 1'b0, 1'b1, 1'b1);
      chk("t1 fire at T+1", {31'b0, fire4}, 1);
      chk("t1 busy after accept", {31'b0, busy4}, 1);
      chk("t1 step0 operands", {27'b0, acin4, aa2_4, aa1_4, bb2_4, bb1_4}, 5'b0_11_01);
      @(negedge clk);
      chk("t1 fire low in WAIT", {31'b0, fire4}, 0);
      drain4;
      repeat (3) @(negedge clk);
      chk("t1 result held idle", {27'b0, busy4, cout4, sum4}, 6'b0_0_1100);
      // F+1: carry from step 0 reaches step 1 at T+3
      issue4(4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      chk("t2 fire at T+3", {31'b0, fire4}, 1);
      chk("t2 step1 carry-in", {31'b0, acin4}, 1);
      drain4;
      // 3+3 with a stray request and operand change mid-operation
      issue4(4'h3, 4'h3, 1'b0, 4'h6, 1'b0, 1'b0, 1'b1);
      a4 = 4'hF;
      b4 = 4'hF;
      cin4 = 1'b1;
      req4 = 1'b1;
      @(negedge clk);
      req4 = 1'b0;
      drain4;
      repeat (10) @(negedge clk);
      // reset in cycle T+3 aborts without a done pulse
      issue4(4'h5, 4'h6, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      chk("t4 partial sum before reset", {28'b0, sum4}, 4'b0011);
      rst = 1'b1;
      @(negedge clk);
      chk("t4 outputs after abort", {24'b0, busy4, fire4, done4, cout4, sum4}, 0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      // 7+1 then back-to-back 1+1 accepted in the DONE cycle
      issue4(4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      chk("t6 done before back-to-back req", {31'b0, done4}, 1);
      issue4(4'b0001, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1);
      drain4;
      issue4(4'h9, 4'h6, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1);
      drain4;
      issue4(4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1);
      drain4;
      // 8-bit, ADD_LAT=3
      issue8(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);
      chk("t5 step0 operands", {27'b0, acin8, aa2_8, aa1_8, bb2_8, bb1_8}, 5'b1_10_01);
      drain8;
      issue8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      drain8;
      issue8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
      drain8;
      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
